// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one single-ported memory bus between the IF stage
//            (instruction fetch) and the MEM stage (loads/stores from the
//            EX/MEM register). Sequences each bus transaction, formats store
//            data and byte enables from rw_type, sign/zero-extends load data,
//            and raises per-stage stall signals for the pipeline control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STARVE_LIMIT  consecutive data grants allowed while a fetch is pending
//                 (only meaningful with MEM_BUS_STARVE_GUARD_EN)
//   TIMEOUT_CYC   cycles to wait for bus_ack_i before aborting
// Optional build macro
//   MEM_BUS_STARVE_GUARD_EN  enables the fetch starvation guard; without it
//                            data requests always win arbitration.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   if_req_i/addr_i   fetch request (level) and word-aligned address
//   if_rdata_o        fetched instruction, valid with if_valid_o pulse
//   stall_if_o        fetch pending and not completing this cycle
//   mem_read_i/write_i, mem_addr_i, mem_wdata_i, rw_type_i   data request
//   mem_rdata_o       extended load data, valid with mem_valid_o pulse
//   mem_err_o         pulse with mem_valid_o on misaligned/timed-out access
//   stall_mem_o       data access pending and not completing this cycle
//   bus_*             single-ported memory bus (req held until ack)
// ============================================================================
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch side
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        stall_if_o,
  // data side
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [2:0]  rw_type_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_valid_o,
  output logic        mem_err_o,
  output logic        stall_mem_o,
  // memory bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int          TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Parameter sanity checks at elaboration.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYC must be at least 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_bus_arbiter: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       lat_rw_type;
  logic [1:0]       lat_off;
  logic             misalign_pulse;

  logic        dreq;
  logic        is_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;
  logic        starve_hit;
  logic        grant_data;
  logic        grant_fetch;

  assign dreq = mem_read_i | mem_write_i;

  // Byte enables, store lane replication and alignment check for the
  // request currently presented by the MEM stage.
  always_comb begin
    req_be        = 4'b1111;
    req_wdata     = mem_wdata_i;
    is_misaligned = 1'b0;
    case (rw_type_i[1:0])
      2'b00: begin
        req_be    = 4'b0001 << mem_addr_i[1:0];
        req_wdata = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << mem_addr_i[1:0];
        req_wdata     = {2{mem_wdata_i[15:0]}};
        is_misaligned = mem_addr_i[0];
      end
      default: is_misaligned = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  // Load path: move the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shifted = bus_rdata_i >> {lat_off, 3'b000};
    case (lat_rw_type)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

`ifdef MEM_BUS_STARVE_GUARD_EN
  localparam int              STV_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0] starve_cnt;

  // Once the data side has won STARVE_LIMIT times against a waiting fetch,
  // the fetch gets the next contested slot.
  assign starve_hit = (starve_cnt == STV_MAX) & if_req_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_data && !is_misaligned && if_req_i && starve_cnt != STV_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // The misalign pulse cycle still sees the faulting request on the inputs
  // (the pipeline advances at the end of that cycle), so it must not be
  // arbitrated a second time.
  assign grant_data  = (state == IDLE) & dreq & ~misalign_pulse & ~starve_hit;
  assign grant_fetch = (state == IDLE) & if_req_i & ~grant_data;

  assign stall_mem_o = rst_n & dreq & ~((state == DATA) & bus_ack_i) & ~misalign_pulse;
  assign stall_if_o  = rst_n & if_req_i & ~((state == FETCH) & bus_ack_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      lat_rw_type    <= 3'd0;
      lat_off        <= 2'd0;
      misalign_pulse <= 1'b0;
      if_rdata_o     <= '0;
      if_valid_o     <= 1'b0;
      mem_rdata_o    <= '0;
      mem_valid_o    <= 1'b0;
      mem_err_o      <= 1'b0;
      bus_req_o      <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_addr_o     <= '0;
      bus_wdata_o    <= '0;
      bus_be_o       <= '0;
    end else begin
      if_valid_o     <= 1'b0;
      mem_valid_o    <= 1'b0;
      mem_err_o      <= 1'b0;
      misalign_pulse <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_data) begin
            if (is_misaligned) begin
              mem_valid_o    <= 1'b1;
              mem_err_o      <= 1'b1;
              mem_rdata_o    <= '0;
              misalign_pulse <= 1'b1;
            end else begin
              state       <= DATA;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_write_i;   // read+write together is a store
              bus_addr_o  <= mem_addr_i & WORD_MASK;
              bus_be_o    <= req_be;
              bus_wdata_o <= req_wdata;
              lat_rw_type <= rw_type_i;
              lat_off     <= mem_addr_i[1:0];
            end
          end else if (grant_fetch) begin
            state       <= FETCH;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i & WORD_MASK;
            bus_be_o    <= 4'b1111;
            bus_wdata_o <= '0;
          end
        end

        DATA: begin
          if (bus_ack_i) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            mem_valid_o <= 1'b1;
            mem_rdata_o <= bus_we_o ? 32'd0 : load_data;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            mem_valid_o <= 1'b1;
            mem_err_o   <= 1'b1;
            mem_rdata_o <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        FETCH: begin
          if (bus_ack_i) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            // A withdrawn fetch still finishes on the bus but is not reported.
            if (if_req_i) begin
              if_valid_o <= 1'b1;
              if_rdata_o <= bus_rdata_i;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= IDLE;
            bus_req_o  <= 1'b0;
            if_valid_o <= 1'b1;
            if_rdata_o <= NOP_INSN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
